// File: rtl/fir_pack_pkg.sv
// Shared FSM encodings, marker byte and saturation bounds for fir_result_packer.
// FIR_PACK_SYNC_EN adds the SYNC state and its SYNC_BYTE marker.
`ifndef LOG2_CEIL
`define LOG2_CEIL(x) $clog2(x)
`endif

package fir_pack_pkg;

`ifdef FIR_PACK_SYNC_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, SEND = 2'd2} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd2} state_t;
`endif

  function automatic logic signed [63:0] sat_max(input int bytes);
    return (64'sd1 <<< (8 * bytes - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int bytes);
    return -(64'sd1 <<< (8 * bytes - 1));
  endfunction

endpackage

// File: rtl/fir_result_packer_sample_fifo.sv
// Synchronous sample FIFO with show-ahead read; a push while full is only
// taken when a pop frees the slot in the same cycle.
module sample_fifo
  import fir_pack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [`LOG2_CEIL(DEPTH):0]    count
);
  localparam int AW = `LOG2_CEIL(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/fir_result_packer.sv
// Rounds/shifts/saturates FIR results, queues them and streams them LSB byte first.
// Define FIR_PACK_SYNC_EN to prefix every frame with the SYNC_BYTE marker.
module fir_result_packer
  import fir_pack_pkg::*;
#(
  parameter int IN_WIDTH   = 37,
  parameter int SHIFT      = 15,
  parameter int BYTES      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [IN_WIDTH-1:0] fir_data,
  input  logic                       fir_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       sat_flag,
  output logic                       overflow
);
  localparam int OW = BYTES * 8;
  localparam int CW = `LOG2_CEIL(FIFO_DEPTH) + 1;
  localparam logic signed [63:0] MAX_V = sat_max(BYTES);
  localparam logic signed [63:0] MIN_V = sat_min(BYTES);
  localparam logic signed [IN_WIDTH:0] RND =
    (SHIFT == 0) ? '0 : (IN_WIDTH+1)'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1);

  logic signed [IN_WIDTH:0] sum;
  logic signed [IN_WIDTH:0] shifted;
  logic signed [63:0]       wide;
  logic [OW-1:0]            clipped;
  logic                     clip;

  // One guard bit keeps the rounding add from wrapping.
  always_comb begin
    sum     = $signed({fir_data[IN_WIDTH-1], fir_data}) + RND;
    shifted = sum >>> SHIFT;
    wide    = 64'(shifted);
    clipped = '0;
    clip    = 1'b1;
    if (wide > MAX_V)      clipped = MAX_V[OW-1:0];
    else if (wide < MIN_V) clipped = MIN_V[OW-1:0];
    else begin
      clipped = wide[OW-1:0];
      clip    = 1'b0;
    end
  end

  logic          s1_valid_reg;
  logic          s1_sat_reg;
  logic [OW-1:0] s1_data_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_sat_reg   <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= fir_valid;
      if (fir_valid) begin
        s1_data_reg <= clipped;
        s1_sat_reg  <= clip;
      end
    end
  end

  assign sat_flag = s1_valid_reg & s1_sat_reg;

  logic [OW-1:0] head;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_count;
  logic          pop;

  sample_fifo #(.WIDTH(OW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (s1_valid_reg),
    .pop     (pop),
    .wr_data (s1_data_reg),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  logic overflow_reg;

  always_ff @(posedge clk) begin
    if (!rst)                             overflow_reg <= 1'b0;
    else if (s1_valid_reg & full & ~pop)  overflow_reg <= 1'b1;
  end

  assign overflow = overflow_reg;

  state_t        state_reg, state_next;
  logic [OW-1:0] shreg_reg, shreg_next;
  logic [2:0]    cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    pop        = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shreg_next = head;
          cnt_next   = '0;
`ifdef FIR_PACK_SYNC_EN
          state_next = SYNC;
`else
          state_next = SEND;
`endif
        end
      end
`ifdef FIR_PACK_SYNC_EN
      SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) state_next = SEND;
      end
`endif
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = shreg_reg[7:0];
        if (tx_ready) begin
          shreg_next = shreg_reg >> 8;
          cnt_next   = cnt_reg + 3'd1;
          if (cnt_reg == 3'(BYTES - 1)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (fifo_count != '0) | (state_reg != IDLE) | s1_valid_reg;
endmodule

// File: tb/tb_fir_result_packer.sv
// Randomized self-checking bench for fir_result_packer against a sample-level
// arithmetic model; honours FIR_PACK_SYNC_EN when the design is built with it.
module tb_fir_result_packer;
  localparam int IN_WIDTH   = 37;
  localparam int SHIFT      = 15;
  localparam int BYTES      = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int OW         = BYTES * 8;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic signed [IN_WIDTH-1:0] fir_data = '0;
  logic                       fir_valid = 1'b0;
  logic [7:0]                 tx_data;
  logic                       tx_valid;
  logic                       tx_ready = 1'b1;
  logic                       busy;
  logic                       sat_flag;
  logic                       overflow;

  fir_result_packer #(.IN_WIDTH(IN_WIDTH), .SHIFT(SHIFT), .BYTES(BYTES),
                      .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .fir_data(fir_data), .fir_valid(fir_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .sat_flag(sat_flag), .overflow(overflow));

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         sat_cnt = 0;
  int         exp_sat = 0;

  // Byte accepted at the coming edge; reset edges are excluded.
  always @(negedge clk) begin
    if (rst && tx_valid && tx_ready) rx_q.push_back(tx_data);
    if (rst && sat_flag) sat_cnt++;
  end

  function automatic logic [OW-1:0] model_sample(input longint d, output bit sat);
    longint r, mx, mn;
    if (SHIFT > 0) r = (d + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    else r = d;
    mx = (longint'(1) << (OW - 1)) - 1;
    mn = -(longint'(1) << (OW - 1));
    sat = 1'b0;
    if (r > mx) begin r = mx; sat = 1'b1; end
    else if (r < mn) begin r = mn; sat = 1'b1; end
    return r[OW-1:0];
  endfunction

  task automatic push_exp(input longint d);
    bit sat;
    logic [OW-1:0] s;
    s = model_sample(d, sat);
    if (sat) exp_sat++;
`ifdef FIR_PACK_SYNC_EN
    exp_q.push_back(8'hA5);
`endif
    for (int i = 0; i < BYTES; i++) exp_q.push_back(s[i*8 +: 8]);
  endtask

  task automatic send(input longint d);
    @(posedge clk); #1;
    fir_data  = d[IN_WIDTH-1:0];
    fir_valid = 1'b1;
    push_exp(d);
    @(posedge clk); #1;
    fir_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 400);
    n_cmp++;
    if (busy) begin
      n_err++;
      $display("FAIL %s_idle: busy=%0b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL rst_sat_flag: got %b want 0", sat_flag); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_basic;
    int b = rx_q.size();
    int s = sat_cnt;
    int rise = -1;
    exp_q.delete(); exp_sat = 0;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    fir_data = 37'sd98304; fir_valid = 1'b1;
    push_exp(98304);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (tx_valid && rise < 0) rise = k;
      if (k == 0) begin @(posedge clk); #1; fir_valid = 1'b0; end
    end
    n_cmp++; if (rise !== 3) begin n_err++; $display("FAIL basic_latency: tx_valid rose at cycle %0d, want 3", rise); end
    wait_idle("basic");
    n_cmp++; if (rx_q.size() - b !== exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d bytes want %0d", rx_q.size() - b, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && b + i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[b+i] !== exp_q[i]) begin n_err++; $display("FAIL basic_byte%0d: got %h want %h", i, rx_q[b+i], exp_q[i]); end
    end
    n_cmp++; if (sat_cnt - s !== exp_sat) begin n_err++; $display("FAIL basic_sat: got %0d pulses want %0d", sat_cnt - s, exp_sat); end
  endtask

  task automatic test_values(input string name, input longint v0, input longint v1);
    int b = rx_q.size();
    int s = sat_cnt;
    exp_q.delete(); exp_sat = 0;
    tx_ready = 1'b1;
    send(v0); repeat (6) @(posedge clk);
    send(v1);
    wait_idle(name);
    n_cmp++; if (rx_q.size() - b !== exp_q.size()) begin n_err++; $display("FAIL %s_count: got %0d bytes want %0d", name, rx_q.size() - b, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && b + i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[b+i] !== exp_q[i]) begin n_err++; $display("FAIL %s_byte%0d: got %h want %h", name, i, rx_q[b+i], exp_q[i]); end
    end
    n_cmp++; if (sat_cnt - s !== exp_sat) begin n_err++; $display("FAIL %s_sat: got %0d pulses want %0d", name, sat_cnt - s, exp_sat); end
  endtask

  task automatic test_backpressure;
    int b = rx_q.size();
    int n = 0;
    exp_q.delete(); exp_sat = 0;
    tx_ready = 1'b0;
    send(longint'($urandom_range(0, 2000000)) - 1000000);
    while (!tx_valid && n < 20) begin @(negedge clk); n++; end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin n_err++; $display("FAIL bp_hold%0d: valid=%b data=%h want valid=1 data=%h", c, tx_valid, tx_data, exp_q[0]); end
    end
    n_cmp++; if (rx_q.size() !== b) begin n_err++; $display("FAIL bp_no_accept: got %0d bytes want 0", rx_q.size() - b); end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle("bp");
    n_cmp++; if (rx_q.size() - b !== exp_q.size()) begin n_err++; $display("FAIL bp_count: got %0d bytes want %0d", rx_q.size() - b, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && b + i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[b+i] !== exp_q[i]) begin n_err++; $display("FAIL bp_byte%0d: got %h want %h", i, rx_q[b+i], exp_q[i]); end
    end
  endtask

  task automatic test_random;
    int b = rx_q.size();
    int s = sat_cnt;
    longint d;
    exp_q.delete(); exp_sat = 0;
    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(2))
        0: d = longint'($urandom_range(0, 200000)) - 100000;
        1: d = longint'($signed($urandom));
        default: begin d = longint'({$urandom, $urandom}); d = (d <<< 27) >>> 27; end
      endcase
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        fir_valid = (c == 0);
        if (c == 0) begin fir_data = d[IN_WIDTH-1:0]; push_exp(d); end
        tx_ready = ($urandom_range(3) != 0);
      end
    end
    @(posedge clk); #1 fir_valid = 1'b0; tx_ready = 1'b1;
    wait_idle("rand");
    n_cmp++; if (rx_q.size() - b !== exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d bytes want %0d", rx_q.size() - b, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && b + i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[b+i] !== exp_q[i]) begin n_err++; $display("FAIL rand_byte%0d: got %h want %h", i, rx_q[b+i], exp_q[i]); end
    end
    n_cmp++; if (sat_cnt - s !== exp_sat) begin n_err++; $display("FAIL rand_sat: got %0d pulses want %0d", sat_cnt - s, exp_sat); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rand_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_overflow;
    int b = rx_q.size();
    logic [7:0] keep[$];
    exp_q.delete(); exp_sat = 0;
    tx_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      send(longint'($urandom_range(0, 4000000)) - 2000000);
      if (k == 4) keep = exp_q;
      @(posedge clk);
    end
    repeat (4) @(negedge clk);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    exp_q = keep;
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle("ovf");
    n_cmp++; if (rx_q.size() - b !== exp_q.size()) begin n_err++; $display("FAIL ovf_count: got %0d bytes want %0d", rx_q.size() - b, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && b + i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[b+i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[b+i], exp_q[i]); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_midframe;
    int b = rx_q.size();
    int n = 0;
    exp_q.delete(); exp_sat = 0;
    tx_ready = 1'b0;
    send(longint'($urandom_range(0, 4000000)) - 2000000);
    @(posedge clk);
    send(longint'($urandom_range(0, 4000000)) - 2000000);
    while (!tx_valid && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 tx_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_overflow: got %b want 0", overflow); end
    repeat (20) @(negedge clk);
    n_cmp++; if (rx_q.size() - b !== 1) begin n_err++; $display("FAIL mid_count: got %0d bytes want 1", rx_q.size() - b); end
    if (rx_q.size() > b) begin
      n_cmp++; if (rx_q[b] !== exp_q[0]) begin n_err++; $display("FAIL mid_byte0: got %h want %h", rx_q[b], exp_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values("round_pos", 16384, -16384);
    test_values("round_neg", -16385, 49151);
    test_values("sat", 64'sd2147483648, -64'sd2147483648);
    test_backpressure();
    test_random();
    test_overflow();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fir_result_packer.md
Name: fir_result_packer

Overview:
- Downstream stage of the FIR filter: consumes the filter's wide signed result and its one-cycle valid pulse.
- Rounds and arithmetic-shifts the result to a fixed-point sample, then saturates it to BYTES*8 bits.
- Buffers samples in a small FIFO and serializes each one LSB-byte-first onto a valid/ready byte stream feeding the UART transmitter.

Parameters:
- IN_WIDTH, 37, width of the FIR result (2*16 + LOG2_CEIL(64) - 1).
- SHIFT, 15, right-shift applied with rounding; 0 means no shift and no rounding.
- BYTES, 2, output sample width in bytes (1..4).
- FIFO_DEPTH, 4, sample FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 at a posedge resets).
- fir_data  in  IN_WIDTH  signed FIR result; valid only when fir_valid=1.
- fir_valid  in  1  one-cycle strobe marking fir_data.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte on a cycle where tx_valid & tx_ready.
- busy  out  1  high when the FIFO is non-empty or a frame is in progress.
- sat_flag  out  1  one-cycle pulse when the stored sample was clipped.
- overflow  out  1  sticky; set when a sample is dropped because the FIFO is full.

Behaviour:
- Reset values: tx_data=0, tx_valid=0, busy=0, sat_flag=0, overflow=0. The FIFO is emptied, the FSM goes to IDLE, and the pipeline register is cleared.
- Reset mid-frame: the partially sent sample and all queued samples are discarded. tx_valid is low in the cycle after the reset edge.
- Conditioning, stage 1 (registered):
  - r = (fir_data + (1 << (SHIFT-1))) >>> SHIFT, rounding half toward +inf.
  - The add is done at IN_WIDTH+1 bits so it cannot wrap.
  - r is clipped to [-2^(8*BYTES-1), 2^(8*BYTES-1)-1].
  - The register loads on fir_valid. Its valid bit is fir_valid delayed one cycle.
  - sat_flag goes high in the same cycle that stage 1 holds a clipped value.
- FIFO write happens at the edge after stage 1 is valid, i.e. 2 edges after fir_valid is sampled.
- Full handling:
  - Write while full with no pop in the same cycle: the sample is dropped and overflow is set to 1.
  - Simultaneous write and pop while full: the write is accepted and the count is unchanged.
- Serializer FSM:
  - IDLE: when the FIFO is non-empty, pop into the shift register, clear the byte counter, go to SEND.
  - SEND: tx_valid=1 and tx_data=shreg[7:0].
    - On tx_valid & tx_ready, shift shreg right by 8 and increment the counter.
    - After byte BYTES-1 is accepted, return to IDLE. This gives one bubble cycle between frames.
  - Without a handshake, tx_valid and tx_data hold stable indefinitely.
- Latency: with the FIFO empty and the FSM in IDLE, tx_valid rises 3 cycles after the fir_valid cycle (stage 1, FIFO write, pop).
- Byte order is LSB first; negative samples appear in two's complement.
- busy = FIFO non-empty | state != IDLE | stage-1 valid.

Optional Feature:
- Macro FIR_PACK_SYNC_EN.
- Defined: a SYNC state is inserted between IDLE and SEND. It emits the byte 8'hA5 under the same handshake before the sample bytes, so a frame is BYTES+1 bytes.
- Undefined: the SYNC state and its constant are not compiled, and a frame is exactly BYTES bytes.

Decomposition:
- Shared package fir_pack_pkg holds:
  - FSM state encodings (IDLE, SYNC, SEND).
  - The SYNC_BYTE constant 8'hA5.
  - Saturation min/max helper functions.
- Pointer widths use LOG2_CEIL from the shared macros.
- One sub-module, sample_fifo: a synchronous FIFO of width BYTES*8 and depth FIFO_DEPTH with push, pop, full, empty and count, reset by the same active-low synchronous rst.

Test Plan:
- Basic: fir_data=98304 (3*2^15), tx_ready=1 -> tx_valid rises 3 cycles later; bytes 0x03, 0x00; sat_flag stays 0.
- Rounding: fir_data=16384 -> 0x01,0x00; fir_data=-16384 -> 0x00,0x00; fir_data=-16385 -> 0xFF,0xFF.
- Saturation: fir_data=2^31 -> 0xFF,0x7F with a sat_flag pulse; fir_data=-2^31 -> 0x00,0x80 with a sat_flag pulse.
- Backpressure: hold tx_ready=0 for 10 cycles mid-frame -> tx_valid and tx_data stable throughout; the second byte appears only after the first handshake.
- Overflow: tx_ready=0, then 6 fir_valid pulses 3 cycles apart -> overflow=1, with 1 sample in the shift register, 4 in the FIFO and 1 dropped; releasing tx_ready gives exactly 10 bytes in order.
- Reset mid-frame: rst=0 for one edge after the first byte of a frame -> all outputs at reset values next cycle; no further bytes; overflow cleared. With FIR_PACK_SYNC_EN defined, the basic test yields 0xA5, 0x03, 0x00.
